dct_block_checker: RTL and testbench

- Synthesizable, parametrised sequencer/checker for block-transform DUTs such as the 2D DCT.
- Accepts one stimulus vector and its golden vector per transaction and drives the DUT with a one-cycle start pulse.
- Waits for the DUT's transfer-complete strobe, with a timeout, then compares the outputs element by element against a runtime absolute-error tolerance.
- Keeps pass/fail statistics and first-failure diagnostics, so regressions can run on FPGA as well as in simulation.

---
 rtl/dct_block_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_dct_block_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_checker.sv
// Sequencer/checker for block-transform DUTs: drives one stimulus block, waits for
// completion with a timeout, compares against golden data with a tolerance and keeps stats.
module dct_block_checker #(
   parameter int N_ELEM  = 64,
   parameter int W       = 9,
   parameter int TOL_W   = 8,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      rst_,
   input  logic                      vec_valid,
   output logic                      vec_ready,
   input  logic [N_ELEM*W-1:0]       stim_x,
   input  logic [N_ELEM*W-1:0]       gold_y,
   input  logic [TOL_W-1:0]          tol,
   output logic [N_ELEM*W-1:0]       dut_x,
   output logic                      dut_start,
   input  logic [N_ELEM*W-1:0]       dut_y,
   input  logic                      dut_xfc,
   output logic                      res_valid,
   output logic                      res_pass,
   output logic                      res_timeout,
   output logic [$clog2(N_ELEM):0]   err_cnt,
   output logic [$clog2(N_ELEM)-1:0] first_idx,
   output logic [W-1:0]              first_got,
   output logic [W-1:0]              first_gold,
   output logic [CNT_W-1:0]          pass_total,
   output logic [CNT_W-1:0]          fail_total,
   output logic                      spurious_xfc,
   output logic                      busy
);

   localparam int IDX_W = $clog2(N_ELEM);
   localparam int ERR_W = IDX_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int D_W   = W + 1;
   localparam int CMP_W = (D_W > TOL_W) ? D_W : TOL_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [N_ELEM*W-1:0]  gold_r;
   logic [N_ELEM*W-1:0]  resp_r;
   logic [TOL_W-1:0]     tol_r;
   logic [TMR_W-1:0]     timer_r;
   logic [IDX_W-1:0]     idx_r;
   logic [W-1:0]         got_s;
   logic [W-1:0]         gold_s;
   logic [D_W-1:0]       absd_s;
   logic                 mism_s;
   logic [ERR_W-1:0]     err_nxt_s;
   logic                 accept_s;
   logic                 timer_last_s;
   logic                 idx_last_s;

   // |a-b| at W+1 bits so that the full signed span (2^W-1) cannot overflow
   function automatic logic [D_W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [D_W-1:0] d;
      d = {a[W-1], a} - {b[W-1], b};
      if (d[D_W-1]) begin
         abs_diff = ~d + D_W'(1'b1);
      end else begin
         abs_diff = d;
      end
   endfunction

   assign accept_s     = vec_valid & vec_ready;
   assign timer_last_s = (timer_r == TMR_W'(TIMEOUT - 1));
   assign idx_last_s   = (idx_r == IDX_W'(N_ELEM - 1));

   // Next-state logic of the transaction sequencer
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (dut_xfc) begin
               state_nxt_s = ST_CHECK;
            end else if (timer_last_s) begin
               state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_CHECK: begin
            if (idx_last_s) begin
               state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_CHECK;
            end
         end
         ST_REPORT: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Per-element tolerance comparison for the element selected by idx_r
   always_comb begin
      got_s  = resp_r[idx_r*W +: W];
      gold_s = gold_r[idx_r*W +: W];
      absd_s = abs_diff(got_s, gold_s);
      if (state_r == ST_CHECK) begin
         mism_s = (CMP_W'(absd_s) > CMP_W'(tol_r));
      end else begin
         mism_s = 1'b0;
      end
      if (mism_s) begin
         err_nxt_s = err_cnt + ERR_W'(1'b1);
      end else begin
         err_nxt_s = err_cnt;
      end
   end

   // Sequencer state, data capture, result and statistics registers
   always_ff @(posedge clock) begin
      if (!rst_) begin
         state_r      <= ST_IDLE;
         gold_r       <= {(N_ELEM*W){1'b0}};
         resp_r       <= {(N_ELEM*W){1'b0}};
         tol_r        <= {TOL_W{1'b0}};
         timer_r      <= {TMR_W{1'b0}};
         idx_r        <= {IDX_W{1'b0}};
         vec_ready    <= 1'b0;
         dut_x        <= {(N_ELEM*W){1'b0}};
         dut_start    <= 1'b0;
         res_valid    <= 1'b0;
         res_pass     <= 1'b0;
         res_timeout  <= 1'b0;
         err_cnt      <= {ERR_W{1'b0}};
         first_idx    <= {IDX_W{1'b0}};
         first_got    <= {W{1'b0}};
         first_gold   <= {W{1'b0}};
         pass_total   <= {CNT_W{1'b0}};
         fail_total   <= {CNT_W{1'b0}};
         spurious_xfc <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         vec_ready <= (state_nxt_s == ST_IDLE);
         busy      <= (state_nxt_s != ST_IDLE);
         dut_start <= (state_nxt_s == ST_START);
         res_valid <= (state_nxt_s == ST_REPORT);
         if (dut_xfc && (state_r != ST_WAIT)) begin
            spurious_xfc <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  dut_x       <= stim_x;
                  gold_r      <= gold_y;
                  tol_r       <= tol;
                  err_cnt     <= {ERR_W{1'b0}};
                  first_idx   <= {IDX_W{1'b0}};
                  first_got   <= {W{1'b0}};
                  first_gold  <= {W{1'b0}};
                  res_pass    <= 1'b0;
                  res_timeout <= 1'b0;
               end
            end
            ST_START: begin
               timer_r <= {TMR_W{1'b0}};
            end
            ST_WAIT: begin
               if (dut_xfc) begin
                  resp_r <= dut_y;
                  idx_r  <= {IDX_W{1'b0}};
               end else if (timer_last_s) begin
                  res_timeout <= 1'b1;
                  res_pass    <= 1'b0;
                  if (fail_total != {CNT_W{1'b1}}) begin
                     fail_total <= fail_total + CNT_W'(1'b1);
                  end
               end else begin
                  timer_r <= timer_r + TMR_W'(1'b1);
               end
            end
            ST_CHECK: begin
               err_cnt <= err_nxt_s;
               idx_r   <= idx_r + IDX_W'(1'b1);
               if (mism_s && (err_cnt == {ERR_W{1'b0}})) begin
                  first_idx  <= idx_r;
                  first_got  <= got_s;
                  first_gold <= gold_s;
               end
               // Result is resolved on the last element so it is visible in REPORT
               if (idx_last_s) begin
                  res_pass    <= (err_nxt_s == {ERR_W{1'b0}});
                  res_timeout <= 1'b0;
                  if (err_nxt_s == {ERR_W{1'b0}}) begin
                     if (pass_total != {CNT_W{1'b1}}) begin
                        pass_total <= pass_total + CNT_W'(1'b1);
                     end
                  end else begin
                     if (fail_total != {CNT_W{1'b1}}) begin
                        fail_total <= fail_total + CNT_W'(1'b1);
                     end
                  end
               end
            end
            ST_REPORT: begin
               timer_r <= {TMR_W{1'b0}};
            end
            default: begin
               timer_r <= {TMR_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dct_block_checker.sv
// Directed self-checking bench for dct_block_checker with a small delayed-response DUT model.
module tb_dct_block_checker;

   localparam int N     = 64;
   localparam int W     = 9;
   localparam int TOL_W = 8;
   localparam int TMO   = 1024;
   localparam int CNT_W = 3;   // narrow counters so saturation is reachable quickly

   logic                 clock = 1'b0;
   logic                 rst_;
   logic                 vec_valid;
   logic                 vec_ready;
   logic [N*W-1:0]       stim_x;
   logic [N*W-1:0]       gold_y;
   logic [TOL_W-1:0]     tol;
   logic [N*W-1:0]       dut_x;
   logic                 dut_start;
   logic [N*W-1:0]       dut_y;
   logic                 dut_xfc;
   logic                 res_valid;
   logic                 res_pass;
   logic                 res_timeout;
   logic [6:0]           err_cnt;
   logic [5:0]           first_idx;
   logic [W-1:0]         first_got;
   logic [W-1:0]         first_gold;
   logic [CNT_W-1:0]     pass_total;
   logic [CNT_W-1:0]     fail_total;
   logic                 spurious_xfc;
   logic                 busy;

   logic tb_xfc = 1'b0;
   logic model_xfc = 1'b0;
   bit   model_en = 1'b0;
   int   model_delay = 5;
   int   model_cnt = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   xfc_cyc = 0;
   int   start_pulses = 0;
   int   res_pulses = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   assign dut_xfc = tb_xfc | model_xfc;

   dct_block_checker #(
      .N_ELEM(N), .W(W), .TOL_W(TOL_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .rst_(rst_), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .stim_x(stim_x), .gold_y(gold_y), .tol(tol), .dut_x(dut_x), .dut_start(dut_start),
      .dut_y(dut_y), .dut_xfc(dut_xfc), .res_valid(res_valid), .res_pass(res_pass),
      .res_timeout(res_timeout), .err_cnt(err_cnt), .first_idx(first_idx),
      .first_got(first_got), .first_gold(first_gold), .pass_total(pass_total),
      .fail_total(fail_total), .spurious_xfc(spurious_xfc), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // DUT model: raises dut_xfc for one cycle model_delay cycles after dut_start
   always @(negedge clock) begin
      if (dut_start) begin
         start_pulses++;
         start_cyc = cyc;
      end
      if (res_valid) res_pulses++;
      if (model_cnt != 0) begin
         model_cnt--;
         if (model_cnt == 0) begin
            model_xfc = 1'b1;
            xfc_cyc = cyc;
         end else begin
            model_xfc = 1'b0;
         end
      end else begin
         model_xfc = 1'b0;
      end
      if (dut_start && model_en) model_cnt = model_delay;
   end

   task automatic fill(input logic [W-1:0] g, input logic [W-1:0] y);
      for (int i = 0; i < N; i++) begin
         gold_y[i*W +: W] = g;
         dut_y[i*W +: W]  = y;
      end
   endtask

   task automatic send_vec();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (vec_ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         vec_valid = 1'b1;
         @(negedge clock);
         vec_valid = 1'b0;
      end
   endtask

   task automatic wait_result(input int limit, output bit got, output int rc);
      got = 1'b0;
      rc = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (res_valid) begin
            got = 1'b1;
            rc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_ = 1'b0; vec_valid = 1'b0; tol = 8'd0;
      stim_x = '0; fill(9'd0, 9'd0);
      repeat (3) @(negedge clock);
      n_checks++; if (vec_ready !== 1'b0) $display("FAIL rst vec_ready got %b want 0", vec_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst busy got %b want 0", busy); else n_pass++;
      n_checks++; if (dut_start !== 1'b0) $display("FAIL rst dut_start got %b want 0", dut_start); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL rst res_valid got %b want 0", res_valid); else n_pass++;
      n_checks++; if (pass_total !== 3'd0) $display("FAIL rst pass_total got %0d want 0", pass_total); else n_pass++;
      n_checks++; if (fail_total !== 3'd0) $display("FAIL rst fail_total got %0d want 0", fail_total); else n_pass++;
      n_checks++; if (spurious_xfc !== 1'b0) $display("FAIL rst spurious got %b want 0", spurious_xfc); else n_pass++;
      n_checks++; if (dut_x !== {(N*W){1'b0}}) $display("FAIL rst dut_x nonzero got %h", dut_x[63:0]); else n_pass++;
      n_checks++; if (err_cnt !== 7'd0) $display("FAIL rst err_cnt got %0d want 0", err_cnt); else n_pass++;
      rst_ = 1'b1;
      @(negedge clock);
      n_checks++; if (vec_ready !== 1'b1) $display("FAIL rst_rel vec_ready got %b want 1", vec_ready); else n_pass++;
   endtask

   task automatic test_exact();
      bit got; int rc;
      stim_x = '0; fill(9'd0, 9'd0); tol = 8'd0;
      model_en = 1'b1; model_delay = 5;
      send_vec();
      n_checks++; if (dut_start !== 1'b1) $display("FAIL exact dut_start got %b want 1", dut_start); else n_pass++;
      n_checks++; if (vec_ready !== 1'b0) $display("FAIL exact vec_ready_busy got %b want 0", vec_ready); else n_pass++;
      wait_result(300, got, rc);
      n_checks++; if (got !== 1'b1) $display("FAIL exact res_valid_seen got %b want 1", got); else n_pass++;
      n_checks++; if (res_pass !== 1'b1) $display("FAIL exact res_pass got %b want 1", res_pass); else n_pass++;
      n_checks++; if (res_timeout !== 1'b0) $display("FAIL exact res_timeout got %b want 0", res_timeout); else n_pass++;
      n_checks++; if (err_cnt !== 7'd0) $display("FAIL exact err_cnt got %0d want 0", err_cnt); else n_pass++;
      n_checks++; if (pass_total !== 3'd1) $display("FAIL exact pass_total got %0d want 1", pass_total); else n_pass++;
      n_checks++; if (rc - xfc_cyc !== 65) $display("FAIL exact latency got %0d want 65", rc - xfc_cyc); else n_pass++;
      @(negedge clock);
      n_checks++; if (res_valid !== 1'b0) $display("FAIL exact res_valid_width got %b want 0", res_valid); else n_pass++;
   endtask

   task automatic test_tol_edge();
      bit got; int rc;
      for (int i = 0; i < N; i++) stim_x[i*W +: W] = W'(i);
      fill(9'd100, 9'd110); tol = 8'd10;
      send_vec();
      n_checks++; if (dut_x !== stim_x) $display("FAIL tol dut_x got %h want %h", dut_x[63:0], stim_x[63:0]); else n_pass++;
      wait_result(300, got, rc);
      n_checks++; if (res_pass !== 1'b1) $display("FAIL tol10 res_pass got %b want 1", res_pass); else n_pass++;
      n_checks++; if (err_cnt !== 7'd0) $display("FAIL tol10 err_cnt got %0d want 0", err_cnt); else n_pass++;
      n_checks++; if (pass_total !== 3'd2) $display("FAIL tol10 pass_total got %0d want 2", pass_total); else n_pass++;
      tol = 8'd9;
      send_vec();
      wait_result(300, got, rc);
      n_checks++; if (res_pass !== 1'b0) $display("FAIL tol9 res_pass got %b want 0", res_pass); else n_pass++;
      n_checks++; if (err_cnt !== 7'd64) $display("FAIL tol9 err_cnt got %0d want 64", err_cnt); else n_pass++;
      n_checks++; if (first_idx !== 6'd0) $display("FAIL tol9 first_idx got %0d want 0", first_idx); else n_pass++;
      n_checks++; if (first_got !== 9'd110) $display("FAIL tol9 first_got got %0d want 110", first_got); else n_pass++;
      n_checks++; if (first_gold !== 9'd100) $display("FAIL tol9 first_gold got %0d want 100", first_gold); else n_pass++;
      n_checks++; if (fail_total !== 3'd1) $display("FAIL tol9 fail_total got %0d want 1", fail_total); else n_pass++;
   endtask

   task automatic test_sign();
      bit got; int rc;
      fill(9'd5, 9'd5);
      gold_y[37*W +: W] = 9'h100;
      dut_y[37*W +: W]  = 9'h0FF;
      tol = 8'd10;
      send_vec();
      wait_result(300, got, rc);
      n_checks++; if (res_pass !== 1'b0) $display("FAIL sign res_pass got %b want 0", res_pass); else n_pass++;
      n_checks++; if (err_cnt !== 7'd1) $display("FAIL sign err_cnt got %0d want 1", err_cnt); else n_pass++;
      n_checks++; if (first_idx !== 6'd37) $display("FAIL sign first_idx got %0d want 37", first_idx); else n_pass++;
      n_checks++; if (first_got !== 9'h0FF) $display("FAIL sign first_got got %h want 0ff", first_got); else n_pass++;
      n_checks++; if (first_gold !== 9'h100) $display("FAIL sign first_gold got %h want 100", first_gold); else n_pass++;
      n_checks++; if (fail_total !== 3'd2) $display("FAIL sign fail_total got %0d want 2", fail_total); else n_pass++;
      tol = 8'hFF;
      send_vec();
      wait_result(300, got, rc);
      n_checks++; if (err_cnt !== 7'd1) $display("FAIL maxd err_cnt got %0d want 1", err_cnt); else n_pass++;
      n_checks++; if (fail_total !== 3'd3) $display("FAIL maxd fail_total got %0d want 3", fail_total); else n_pass++;
   endtask

   task automatic test_timeout();
      bit got; int rc;
      model_en = 1'b0;
      fill(9'd0, 9'd0); tol = 8'd0;
      send_vec();
      wait_result(1200, got, rc);
      n_checks++; if (got !== 1'b1) $display("FAIL tmo res_valid_seen got %b want 1", got); else n_pass++;
      n_checks++; if (res_timeout !== 1'b1) $display("FAIL tmo res_timeout got %b want 1", res_timeout); else n_pass++;
      n_checks++; if (res_pass !== 1'b0) $display("FAIL tmo res_pass got %b want 0", res_pass); else n_pass++;
      n_checks++; if (rc - start_cyc !== 1025) $display("FAIL tmo latency got %0d want 1025", rc - start_cyc); else n_pass++;
      n_checks++; if (fail_total !== 3'd4) $display("FAIL tmo fail_total got %0d want 4", fail_total); else n_pass++;
      @(negedge clock);
      n_checks++; if (vec_ready !== 1'b1) $display("FAIL tmo vec_ready got %b want 1", vec_ready); else n_pass++;
      model_en = 1'b1;
   endtask

   task automatic test_spurious();
      n_checks++; if (spurious_xfc !== 1'b0) $display("FAIL spur pre got %b want 0", spurious_xfc); else n_pass++;
      @(negedge clock); tb_xfc = 1'b1;
      @(negedge clock); tb_xfc = 1'b0;
      @(negedge clock);
      n_checks++; if (spurious_xfc !== 1'b1) $display("FAIL spur set got %b want 1", spurious_xfc); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL spur busy got %b want 0", busy); else n_pass++;
      repeat (5) @(negedge clock);
      n_checks++; if (spurious_xfc !== 1'b1) $display("FAIL spur sticky got %b want 1", spurious_xfc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s0, r0;
      fill(9'd0, 9'd0); tol = 8'd0; model_delay = 3;
      s0 = start_pulses; r0 = res_pulses;
      @(negedge clock);
      vec_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (start_pulses - s0 >= 3) break;
      end
      vec_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (res_pulses - r0 >= 3) break;
      end
      repeat (20) @(negedge clock);
      n_checks++; if (start_pulses - s0 !== 3) $display("FAIL b2b starts got %0d want 3", start_pulses - s0); else n_pass++;
      n_checks++; if (res_pulses - r0 !== 3) $display("FAIL b2b results got %0d want 3", res_pulses - r0); else n_pass++;
      n_checks++; if (pass_total !== 3'd5) $display("FAIL b2b pass_total got %0d want 5", pass_total); else n_pass++;
      n_checks++; if (spurious_xfc !== 1'b1) $display("FAIL b2b spurious got %b want 1", spurious_xfc); else n_pass++;
   endtask

   task automatic test_saturation();
      bit got; int rc;
      logic [CNT_W-1:0] exp_pt;
      fill(9'd0, 9'd0); tol = 8'd0;
      for (int k = 0; k < 3; k++) begin
         exp_pt = (k == 0) ? 3'd6 : 3'd7;
         send_vec();
         wait_result(300, got, rc);
         n_checks++; if (pass_total !== exp_pt) $display("FAIL sat pass_total[%0d] got %0d want %0d", k, pass_total, exp_pt); else n_pass++;
      end
      n_checks++; if (fail_total !== 3'd4) $display("FAIL sat fail_total got %0d want 4", fail_total); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit found; int r0;
      for (int i = 0; i < N; i++) stim_x[i*W +: W] = W'(i + 1);
      fill(9'd100, 9'd110); tol = 8'd9; model_delay = 4;
      send_vec();
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (model_xfc) begin
            found = 1'b1;
            break;
         end
      end
      repeat (10) @(negedge clock);
      n_checks++; if (found !== 1'b1) $display("FAIL rmid xfc_seen got %b want 1", found); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL rmid busy_pre got %b want 1", busy); else n_pass++;
      rst_ = 1'b0;
      @(negedge clock);
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid busy got %b want 0", busy); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL rmid res_valid got %b want 0", res_valid); else n_pass++;
      n_checks++; if (err_cnt !== 7'd0) $display("FAIL rmid err_cnt got %0d want 0", err_cnt); else n_pass++;
      n_checks++; if (first_got !== 9'd0) $display("FAIL rmid first_got got %0d want 0", first_got); else n_pass++;
      n_checks++; if (pass_total !== 3'd0) $display("FAIL rmid pass_total got %0d want 0", pass_total); else n_pass++;
      n_checks++; if (fail_total !== 3'd0) $display("FAIL rmid fail_total got %0d want 0", fail_total); else n_pass++;
      n_checks++; if (spurious_xfc !== 1'b0) $display("FAIL rmid spurious got %b want 0", spurious_xfc); else n_pass++;
      n_checks++; if (dut_x !== {(N*W){1'b0}}) $display("FAIL rmid dut_x nonzero got %h", dut_x[63:0]); else n_pass++;
      rst_ = 1'b1;
      r0 = res_pulses;
      repeat (100) @(negedge clock);
      n_checks++; if (res_pulses - r0 !== 0) $display("FAIL rmid late_res got %0d want 0", res_pulses - r0); else n_pass++;
      n_checks++; if (vec_ready !== 1'b1) $display("FAIL rmid vec_ready got %b want 1", vec_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_exact();
      test_tol_edge();
      test_sign();
      test_timeout();
      test_spurious();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
